// File: rtl/operand_unpack_stage_pkg.sv
// operand_class: shared operand classes, IEEE-754 binary32 constants and unpacked-operand records.
package operand_class;

    typedef enum logic [2:0] {ZERO, SUBNORMAL, NORMAL, INFINITY, QNAN, SNAN} operand_class;

    localparam logic [7:0] EXP_MAX        = 8'd255;
    localparam int         FRACTION_WIDTH = 23;

    typedef struct packed {
        logic                    sign;
        logic [7:0]              exponent;
        logic [FRACTION_WIDTH:0] fraction;
        operand_class            cls;
    } unpacked_t;

    typedef struct packed {
        unpacked_t a;
        unpacked_t b;
    } pair_t;

endpackage

// File: rtl/operand_unpack_stage_classifier.sv
// operand_classifier: combinational binary32 unpack.
//   value    - raw binary32 operand
//   sign     - sign bit
//   exponent - effective biased exponent (subnormals report 1)
//   fraction - hidden bit plus 23-bit fraction
//   cls      - operand class
module operand_classifier
    import operand_class::*;
(
    input  logic [31:0]             value,
    output logic                    sign,
    output logic [7:0]              exponent,
    output logic [FRACTION_WIDTH:0] fraction,
    output operand_class            cls
);
    logic [7:0]                e;
    logic [FRACTION_WIDTH-1:0] f;
    logic                      e_zero;
    logic                      e_max;
    logic                      f_zero;

    assign e      = value[30:23];
    assign f      = value[FRACTION_WIDTH-1:0];
    assign e_zero = e == 8'd0;
    assign e_max  = e == EXP_MAX;
    assign f_zero = f == '0;

    always_comb begin
        sign     = value[31];
        exponent = e_zero ? {7'd0, ~f_zero} : e;
        fraction = {~e_zero, f};
        cls      = e_zero ? (f_zero ? ZERO : SUBNORMAL)
                 : e_max  ? (f_zero ? INFINITY : f[FRACTION_WIDTH-1] ? QNAN : SNAN)
                 : NORMAL;
    end
endmodule

// File: rtl/operand_unpack_stage.sv
// operand_unpack_stage: registered unpack of an operand pair behind a 2-entry skid buffer.
//   clk, reset            - clock, asynchronous active-high reset
//   valid_in / ready_in   - upstream handshake (ready_in straight from a flop)
//   operand_a, operand_b  - binary32 operands
//   valid_out / ready_out - downstream handshake
//   sign_*, exponent_*, operand_fraction_*, class_* - unpacked fields
//   invalid               - either operand on the outputs is a signalling NaN
module operand_unpack_stage
    import operand_class::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [31:0]             operand_a,
    input  logic [31:0]             operand_b,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic                    sign_a,
    output logic                    sign_b,
    output logic [7:0]              exponent_a,
    output logic [7:0]              exponent_b,
    output logic [FRACTION_WIDTH:0] operand_fraction_a,
    output logic [FRACTION_WIDTH:0] operand_fraction_b,
    output operand_class            class_a,
    output operand_class            class_b,
    output logic                    invalid
);
    pair_t in_pair;
    pair_t main_q;
    pair_t skid_q;
    logic  in_xfer;
    logic  drain;

    operand_classifier u_class_a (
        .value    (operand_a),
        .sign     (in_pair.a.sign),
        .exponent (in_pair.a.exponent),
        .fraction (in_pair.a.fraction),
        .cls      (in_pair.a.cls)
    );

    operand_classifier u_class_b (
        .value    (operand_b),
        .sign     (in_pair.b.sign),
        .exponent (in_pair.b.exponent),
        .fraction (in_pair.b.fraction),
        .cls      (in_pair.b.cls)
    );

    assign in_xfer = valid_in && ready_in;
    // main register can take new data this edge: empty or being consumed
    assign drain   = !valid_out || ready_out;

    // ready_in doubles as the "skid empty" flag; an input transfer only
    // happens while skid is empty, so skid and in_pair never compete for main
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out <= 1'b0;
            ready_in  <= 1'b1;
            main_q    <= '0;
            skid_q    <= '0;
        end else if (drain) begin
            valid_out <= !ready_in || in_xfer;
            ready_in  <= 1'b1;
            if (!ready_in)
                main_q <= skid_q;
            else if (in_xfer)
                main_q <= in_pair;
        end else if (in_xfer) begin
            skid_q   <= in_pair;
            ready_in <= 1'b0;
        end
    end

    assign sign_a             = main_q.a.sign;
    assign sign_b             = main_q.b.sign;
    assign exponent_a         = main_q.a.exponent;
    assign exponent_b         = main_q.b.exponent;
    assign operand_fraction_a = main_q.a.fraction;
    assign operand_fraction_b = main_q.b.fraction;
    assign class_a            = main_q.a.cls;
    assign class_b            = main_q.b.cls;
    assign invalid            = main_q.a.cls == SNAN || main_q.b.cls == SNAN;
endmodule

// File: doc/operand_unpack_stage.md
OPERAND_UNPACK_STAGE -- requirements
Module: operand_unpack_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 valid_in  input  1  upstream operand pair valid.
REQ-004 ready_in  output  1  stage can accept a pair; driven directly from a flop.
REQ-005 operand_a, operand_b  input  32 each  IEEE-754 binary32 operands.
REQ-006 valid_out  output  1  unpacked pair valid.
REQ-007 ready_out  input  1  downstream accepts the pair.
REQ-008 sign_a, sign_b  output  1 each  operand sign bits.
REQ-009 exponent_a, exponent_b  output  8 each  effective biased exponents.
REQ-010 operand_fraction_a, operand_fraction_b  output  24 each  hidden bit plus 23-bit fraction.
REQ-011 class_a, class_b  output  operand_class::operand_class  operand class.
REQ-012 invalid  output  1  either operand is a signalling NaN.

Function
REQ-013 A transfer SHALL occur on an input edge when valid_in and ready_in are both 1; an output transfer SHALL occur when valid_out and ready_out are both 1.
REQ-014 Latency SHALL be 1 cycle: a pair accepted at edge N SHALL appear at the outputs with valid_out=1 after edge N when the output register is empty or draining.
REQ-015 Storage SHALL be a main output register plus one skid register, 2 entries total.
REQ-016 ready_in SHALL be 0 only when the skid register is occupied.
REQ-017 Output order SHALL equal input order; no pair SHALL be dropped or duplicated under any ready_out pattern.
REQ-018 With main register full, ready_out=0 and an input transfer, the new pair SHALL go to the skid register.
REQ-019 When main drains while skid is full, skid SHALL move to main and ready_in SHALL return to 1 on the same edge.
REQ-020 With main full, ready_out=1 and an input transfer, the new pair SHALL replace main directly; skid is not used.
REQ-021 Unpacking SHALL be registered with the data.
REQ-022 Unpacking, exp=0, frac=0: class ZERO, exponent 0, fraction 0.
REQ-023 Unpacking, exp=0, frac!=0: class SUBNORMAL, exponent 1, fraction {0,frac}.
REQ-024 Unpacking, exp 1..254: class NORMAL, exponent exp, fraction {1,frac}.
REQ-025 Unpacking, exp=255, frac=0: class INFINITY, exponent 255, fraction {1,0}.
REQ-026 Unpacking, exp=255, frac!=0: class QNAN if frac[22]=1, else SNAN; exponent 255, fraction {1,frac}.
REQ-027 invalid SHALL equal (class_a==SNAN) OR (class_b==SNAN) for the pair on the outputs.
REQ-028 Data outputs SHALL hold their value while valid_out=1 and ready_out=0.

Reset
REQ-029 While reset=1: valid_out=0, skid empty, ready_in=1, all data outputs 0, class outputs ZERO, invalid=0.
REQ-030 Reset asserted mid-operation SHALL discard both stored pairs immediately, without waiting for a clock edge.
REQ-031 The first transfer SHALL be possible on the first edge after reset deasserts.

Structure
REQ-032 Package operand_class SHALL hold enum operand_class (ZERO, SUBNORMAL, NORMAL, INFINITY, QNAN, SNAN), shared with result selection logic.
REQ-033 Package operand_class SHALL hold constants EXP_MAX=8'd255 and FRACTION_WIDTH=23.
REQ-034 The combinational sub-module operand_classifier (32-bit in; sign, exponent, fraction, class out) SHALL be instantiated once per operand.
REQ-035 The handshake/skid logic SHALL reside in operand_unpack_stage.

Verification
REQ-036 Normal operands: a=0x3F800000, b=0xC0000000, ready_out=1 -> next cycle a: sign 0, exp 127, frac 0x800000, NORMAL; b: sign 1, exp 128, frac 0x800000, NORMAL; invalid=0.
REQ-037 Subnormal and zero: a=0x00000001, b=0x80000000 -> a: SUBNORMAL, exp 1, frac 0x000001; b: ZERO, sign 1, exp 0, frac 0.
REQ-038 NaNs: a=0x7FA00000, b=0x7FC00000 -> class_a SNAN, class_b QNAN, invalid=1; a=0x7F800000 -> INFINITY, frac 0x800000.
REQ-039 Backpressure: ready_out=0, three back-to-back pairs offered -> two accepted, ready_in=0 from the second accept; ready_out=1 -> all three emerge in order with no loss, then ready_in=1.
REQ-040 Reset mid-operation: both entries full, reset pulsed between edges -> valid_out=0 and ready_in=1 immediately; no stale pair emerges afterwards.
